// File: rtl/cmp_pkg.sv
// cmp_pkg: shared constants, condition encodings and types for the compare-code decoder.
package cmp_pkg;

    localparam logic [7:0] CMP_CODE_EQ = 8'h00;
    localparam logic [7:0] CMP_CODE_GT = 8'h01;
    localparam logic [7:0] CMP_CODE_LT = 8'hFF;

    typedef enum logic [2:0] {
        COND_EQ     = 3'd0,
        COND_NE     = 3'd1,
        COND_GT     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_LE     = 3'd5,
        COND_ALWAYS = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
        logic taken;
        logic err;
    } res_t;

endpackage

// File: rtl/cmp_cond_eval.sv
// cmp_cond_eval: evaluates a 3-bit branch condition against a one-hot relation.
module cmp_cond_eval
    import cmp_pkg::*;
(
    input  logic       eq_i,
    input  logic       gt_i,
    input  logic       lt_i,
    input  logic       err_i,
    input  logic [2:0] cond_i,
    output logic       taken_o
);

    logic raw;

    always_comb begin
        raw = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ:     raw = eq_i;
            COND_NE:     raw = ~eq_i;
            COND_GT:     raw = gt_i;
            COND_LT:     raw = lt_i;
            COND_GE:     raw = gt_i | eq_i;
            COND_LE:     raw = lt_i | eq_i;
            COND_ALWAYS: raw = 1'b1;
            default:     raw = 1'b0;
        endcase
    end

    // An illegal code never takes a branch, not even ALWAYS.
    assign taken_o = raw & ~err_i;

endmodule

// File: rtl/cmp_code_decoder.sv
// cmp_code_decoder: one-entry registered decoder of compare codes with condition evaluation.
// Define CMP_DECODE_ERRCNT_EN to add the saturating illegal-code counter err_count.
module cmp_code_decoder
    import cmp_pkg::*;
#(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_code,
    input  logic [2:0]          in_cond,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_eq,
    output logic                out_gt,
    output logic                out_lt,
    output logic                out_taken,
    output logic                out_err,
    input  logic                err_clr
`ifdef CMP_DECODE_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    state_e state_q, state_d;
    res_t   res_q, res_d, res_new;
    logic   accept, xfer, taken;

    assign in_ready  = (state_q == ST_EMPTY) | out_ready;
    assign out_valid = (state_q == ST_FULL);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    assign res_new.eq    = (in_code == CMP_CODE_EQ);
    assign res_new.gt    = (in_code == CMP_CODE_GT);
    assign res_new.lt    = (in_code == CMP_CODE_LT);
    assign res_new.err   = ~(res_new.eq | res_new.gt | res_new.lt);
    assign res_new.taken = taken;

    cmp_cond_eval u_cond_eval (
        .eq_i    (res_new.eq),
        .gt_i    (res_new.gt),
        .lt_i    (res_new.lt),
        .err_i   (res_new.err),
        .cond_i  (in_cond),
        .taken_o (taken)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        if (accept) begin
            state_d = ST_FULL;
            res_d   = res_new;
        end else if (xfer) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    assign out_eq    = res_q.eq;
    assign out_gt    = res_q.gt;
    assign out_lt    = res_q.lt;
    assign out_taken = res_q.taken;
    assign out_err   = res_q.err;

`ifdef CMP_DECODE_ERRCNT_EN
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;

    // A clear coinciding with an illegal accept leaves exactly that one error counted.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && res_new.err)
            cnt_d = err_clr ? ERRCNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + ERRCNT_W'(1));
        else if (err_clr)
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign err_count = cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_cmp_code_decoder.sv
// tb_cmp_code_decoder: randomized and directed self-checking bench for cmp_code_decoder.
// Checks err_count when CMP_DECODE_ERRCNT_EN is defined.
module tb_cmp_code_decoder;

    localparam int W = 8;
    localparam int CNT_MAX = (1 << W) - 1;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
    logic [7:0]   in_code = '0;
    logic [2:0]   in_cond = '0;
    logic         in_ready, out_valid, out_eq, out_gt, out_lt, out_taken, out_err;
`ifdef CMP_DECODE_ERRCNT_EN
    logic [W-1:0] err_count;
`endif

    cmp_code_decoder #(.ERRCNT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_cond   (in_cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eq    (out_eq),
        .out_gt    (out_gt),
        .out_lt    (out_lt),
        .out_taken (out_taken),
        .out_err   (out_err),
        .err_clr   (err_clr)
`ifdef CMP_DECODE_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit m_full = 1'b0;
    int m_rel = 0;
    bit m_taken = 1'b0;
    int m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Relation: 0 equal, 1 greater, -1 less, 2 illegal.
    function automatic int rel_of(input logic [7:0] c);
        if (c == 8'h00) return 0;
        if (c == 8'h01) return 1;
        if (c == 8'hFF) return -1;
        return 2;
    endfunction

    function automatic bit taken_of(input int rel, input int cond);
        if (rel == 2) return 1'b0;
        case (cond)
            0: return rel == 0;
            1: return rel != 0;
            2: return rel == 1;
            3: return rel == -1;
            4: return rel >= 0;
            5: return rel <= 0;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, m_full);
        if (m_full) begin
            check("out_eq", out_eq, m_rel == 0);
            check("out_gt", out_gt, m_rel == 1);
            check("out_lt", out_lt, m_rel == -1);
            check("out_err", out_err, m_rel == 2);
            check("out_taken", out_taken, m_taken);
        end
`ifdef CMP_DECODE_ERRCNT_EN
        check("err_count", err_count, m_cnt);
`endif
    endtask

    task automatic step(input bit v, input logic [7:0] code, input logic [2:0] cond,
                        input bit ordy, input bit clr);
        bit acc;
        @(negedge clk);
        in_valid = v; in_code = code; in_cond = cond; out_ready = ordy; err_clr = clr;
        #1 check("in_ready", in_ready, !m_full || ordy);
        acc = v && (!m_full || ordy);
        @(posedge clk);
        #1;
        if (acc) begin
            m_full  = 1'b1;
            m_rel   = rel_of(code);
            m_taken = taken_of(m_rel, cond);
            if (m_rel == 2) m_cnt = clr ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
            else if (clr) m_cnt = 0;
        end else begin
            if (m_full && ordy) m_full = 1'b0;
            if (clr) m_cnt = 0;
        end
        check_outputs();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_outs", {out_eq, out_gt, out_lt, out_taken, out_err}, 0);
`ifdef CMP_DECODE_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif
        m_full = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] illegal_code();
        logic [7:0] c;
        do c = 8'($urandom); while (c == 8'h00 || c == 8'h01 || c == 8'hFF);
        return c;
    endfunction

    initial begin
        logic [7:0] legal [3];
        legal[0] = 8'h00; legal[1] = 8'h01; legal[2] = 8'hFF;
        apply_reset();
        step(1, 8'h01, 3'd4, 1, 0);
        step(1, 8'hFF, 3'd2, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 3'd0, 0, 0);
        step(0, 8'h00, 3'd0, 1, 0);
        step(1, 8'h00, 3'd0, 1, 0);
        step(1, 8'h01, 3'd5, 1, 0);
        step(1, 8'hFF, 3'd1, 1, 0);
        step(0, 8'h00, 3'd0, 1, 0);
        step(1, 8'h7E, 3'd6, 1, 0);
        step(1, 8'h02, 3'd6, 1, 0);
        step(1, 8'h80, 3'd4, 1, 0);
        step(1, 8'hFE, 3'd1, 1, 0);
        step(0, 8'h00, 3'd0, 1, 1);
        step(1, 8'h02, 3'd6, 1, 1);
        for (int i = 0; i < 300; i++) step(1, illegal_code(), 3'($urandom), 1, 0);
        step(1, 8'h02, 3'd0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            logic [7:0] c;
            c = ($urandom_range(3) == 0) ? illegal_code() : legal[$urandom_range(2)];
            step(1'($urandom), c, 3'($urandom), $urandom_range(3) != 0, $urandom_range(15) == 0);
        end
        step(1, 8'h01, 3'd2, 0, 0);
        step(0, 8'h00, 3'd0, 0, 0);
        apply_reset();
        step(0, 8'h00, 3'd0, 0, 0);
        step(1, 8'hFF, 3'd3, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_code_decoder.md
CMP_CODE_DECODER -- requirements
Module: cmp_code_decoder

Interface
REQ-001 Parameter ERRCNT_W, default 8: width of the illegal-code counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_code/in_cond valid this cycle.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 in_code  input  8  compare code: 8'h00 = equal, 8'h01 = A>B, 8'hFF = A<B, all others illegal.
REQ-007 in_cond  input  3  condition select: 0 EQ, 1 NE, 2 GT, 3 LT, 4 GE, 5 LE, 6 ALWAYS, 7 NEVER.
REQ-008 out_valid  output  1  decoded result held in the output register.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_eq, out_gt, out_lt  output  1 each  one-hot decoded relation; all 0 on an illegal code.
REQ-011 out_taken  output  1  in_cond evaluated against the decoded relation.
REQ-012 out_err  output  1  captured code was illegal.
REQ-013 err_clr  input  1  synchronous clear pulse for err_count.
REQ-014 err_count  output  ERRCNT_W  saturating illegal-code count; present only with CMP_DECODE_ERRCNT_EN.

Function
REQ-015 The block SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 in_ready SHALL equal (state==EMPTY) or out_ready, combinationally.
REQ-017 Input SHALL be accepted when in_valid and in_ready are both high. Accepting in EMPTY moves to FULL.
REQ-018 A transfer is out_valid and out_ready both high. FULL with a transfer and no new accept moves to EMPTY. FULL with a transfer and a simultaneous accept stays FULL with the new result.
REQ-019 Latency SHALL be one cycle: a result accepted at edge N is on the outputs after edge N.
REQ-020 While FULL and out_ready=0, all out_* SHALL hold stable and in_ready SHALL be 0.
REQ-021 out_taken SHALL be EQ:eq, NE:!eq, GT:gt, LT:lt, GE:gt|eq, LE:lt|eq, ALWAYS:1, NEVER:0.
REQ-022 On an illegal code: out_err=1, out_eq/gt/lt=0, out_taken=0 for every in_cond, ALWAYS included.
REQ-023 Decoding SHALL compare all 8 bits exactly. 8'h02, 8'h80 and 8'hFE are illegal.

Reset
REQ-024 While rst_n=0: state EMPTY, out_valid=0, out_eq/gt/lt/taken/err=0, err_count=0.
REQ-025 Reset mid-operation SHALL discard any held result with no transfer. in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-026 With CMP_DECODE_ERRCNT_EN defined:
- err_count SHALL increment on each accepted illegal code.
- it SHALL saturate at all-ones.
- err_clr SHALL zero it.
- err_clr together with an accepted illegal code SHALL give 1.
REQ-027 Without CMP_DECODE_ERRCNT_EN:
- the err_count port and counter SHALL be absent.
- err_clr SHALL be ignored.
- all other behaviour SHALL be identical.

Structure
REQ-028 Shared package cmp_pkg SHALL hold:
- code constants CMP_CODE_EQ=8'h00, CMP_CODE_GT=8'h01, CMP_CODE_LT=8'hFF;
- the 3-bit condition encodings;
- the FSM state typedef.
REQ-029 Condition evaluation SHALL be in one combinational sub-module, cmp_cond_eval: (eq, gt, lt, err, cond) -> taken.

Verification
REQ-030 Reset, then code 8'h01 with cond GE and out_ready=1 -> next cycle out_valid=1, out_gt=1, out_taken=1, out_err=0.
REQ-031 Code 8'hFF with cond GT, out_ready=0 for 3 cycles -> outputs stable, in_ready=0; out_ready=1 -> transfer, state EMPTY.
REQ-032 Back-to-back 8'h00/EQ, 8'h01/LE, 8'hFF/NE with out_ready=1 -> one result per cycle, taken = 1, 0, 1.
REQ-033 Code 8'h7E with cond ALWAYS -> out_err=1, out_taken=0; with macro, err_count 0->1; 300 illegal codes -> 8'hFF.
REQ-034 rst_n pulled low while FULL and stalled -> out_valid=0 immediately; after release in_ready=1 and err_count=0.
